crc_serial_engine: RTL and testbench
====================================

// Module: crc_serial_engine
// PURPOSE
//  Parametrised bit-serial CRC engine: generator/checker for serial links. Replaces the fixed CRC-8 LFSR.
//  Generate mode: after the frame, shifts exactly CRC_WIDTH bits out with VALID.
//  Check mode: the frame carries data plus received CRC; one pass/fail flag follows the frame.
//  Auto-reseeds between frames; accepts back-to-back frames.
// PARAMETERS
//  CRC_WIDTH  8      LFSR width in bits, >= 2
//  POLY       8'h44  reflected tap mask; bit i set => fb XORed into lfsr[i]; bit W-1 always takes fb
//  SEED       8'hD8  LFSR value at reset and at every frame start
// PORTS
//  CLK       in   1  clock, rising edge
//  RST       in   1  synchronous reset, active low
//  DATA      in   1  serial data bit, sampled when ACTIVE=1
//  ACTIVE    in   1  frame-bit qualifier; a contiguous high run is one frame
//  MODE      in   1  0=generate, 1=check; sampled on the first ACTIVE cycle of a frame only
//  CRC       out  1  serial CRC bit, LSB (lfsr[0]) first
//  VALID     out  1  CRC bit qualifier, high for exactly CRC_WIDTH cycles per generate frame
//  BUSY      out  1  high in SHIFT or OUT state
//  CHK_DONE  out  1  one-cycle pulse ending a check frame
//  CHK_ERR   out  1  check result, valid with CHK_DONE and held until the next CHK_DONE
// BEHAVIOUR
//  Reset (RST=0 at edge): lfsr=SEED, state=IDLE, cnt=0, mode_q=0.
//   CRC, VALID, BUSY, CHK_DONE and CHK_ERR all = 0. RST overrides every other input.
//  Step function: fb=DATA^lfsr[0]; next=(lfsr>>1) ^ (fb ? ({1'b1,{W-1{1'b0}}} | POLY) : 0).
//  FSM IDLE/SHIFT/OUT; all outputs registered.
//  IDLE: lfsr holds SEED.
//   ACTIVE=1 -> lfsr=step(SEED), mode_q=MODE, go to SHIFT.
//  SHIFT: ACTIVE=1 -> lfsr=step(lfsr).
//   ACTIVE=0 with mode_q=0 -> go to OUT: CRC=lfsr[0], VALID=1, lfsr>>=1, cnt=1.
//   ACTIVE=0 with mode_q=1 -> go to IDLE: CHK_DONE=1, CHK_ERR=(lfsr!=0), lfsr=SEED.
//  OUT, ACTIVE=0: if cnt<W then CRC=lfsr[0], VALID=1, lfsr>>=1, cnt++.
//   If cnt==W then VALID=0, CRC=0, lfsr=SEED, go to IDLE.
//   DATA is ignored in OUT.
//  OUT, ACTIVE=1 (simultaneous new frame): remaining CRC bits are abandoned.
//   VALID=0, lfsr=step(SEED), mode_q=MODE, go to SHIFT.
//  Latency: first CRC bit is registered on the edge that samples ACTIVE low.
//   The last bit is valid W cycles later, and the next frame may start on the following cycle.
//  Check residue: appending the generated CRC LSB-first drives the lfsr to 0.
//   Any nonzero residue => CHK_ERR=1.
//  One-bit frames are legal. cnt width is $clog2(W+1). No final XOR, no output reflection.
//  BUSY=1 in SHIFT and OUT, 0 in IDLE.
// STRUCTURE
//  Shared package crc_pkg: state encoding (IDLE/SHIFT/OUT), MODE_GEN=0 / MODE_CHK=1,
//   default POLY/SEED constants for CRC-8.
//  Sub-module crc_lfsr_step: combinational step(lfsr, DATA) -> next lfsr, parametrised by CRC_WIDTH/POLY.
//   Reused by the parallel CRC block.
// TESTING
//  1. Reset with RST=0 mid-OUT -> next cycle: all outputs 0, state IDLE, lfsr=8'hD8.
//  2. Defaults, MODE=0, 8 bits of DATA=0 -> VALID high exactly 8 cycles.
//   CRC stream 0,0,1,0,1,0,0,0 (8'h14); BUSY falls after the 8th bit.
//  3. MODE=1, frame = 8 zeros + 0,0,1,0,1,0,0,0 -> CHK_DONE pulse, CHK_ERR=0.
//   Same frame with any one bit flipped -> CHK_ERR=1.
//  4. One-bit frame DATA=1, MODE=0 -> CRC=8'hA8 LSB first.
//  5. ACTIVE re-asserted on the 3rd OUT cycle -> VALID drops next edge.
//   The new frame starts from SEED, and its CRC matches an isolated run.
//  6. CRC_WIDTH=16, POLY=16'h8408, SEED=16'hFFFF vs reference model, 1000 random frames
//   with random MODE -> all generated CRCs match; all checks with appended CRC give CHK_ERR=0.

Source files
------------

// File: rtl/crc_serial_engine_pkg.sv
// Shared types and CRC-8 defaults for the serial CRC engine.
// State encoding, mode codes and reset seed/poly constants.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OUT
  } state_e;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  localparam logic [7:0] CRC8_POLY = 8'h44;
  localparam logic [7:0] CRC8_SEED = 8'hD8;

endpackage

// File: rtl/crc_serial_engine_if.sv
// Serial frame-in / CRC-out bundle for crc_serial_engine.
// master drives frame bits, slave is the engine.
interface crc_serial_engine_if;

  logic DATA;
  logic ACTIVE;
  logic MODE;
  logic CRC;
  logic VALID;
  logic BUSY;
  logic CHK_DONE;
  logic CHK_ERR;

  modport master (
    output DATA, ACTIVE, MODE,
    input  CRC, VALID, BUSY, CHK_DONE, CHK_ERR
  );

  modport slave (
    input  DATA, ACTIVE, MODE,
    output CRC, VALID, BUSY, CHK_DONE, CHK_ERR
  );

endinterface

// File: rtl/crc_serial_engine_lfsr_step.sv
// One reflected LFSR step: shift right, fold feedback into taps.
// Pure combinational; shared with the parallel CRC block.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(CRC8_POLY)
) (
  input  logic [CRC_WIDTH-1:0] lfsr_i,
  input  logic                 data_i,
  output logic [CRC_WIDTH-1:0] lfsr_o
);

  // The MSB always receives feedback regardless of the tap mask.
  localparam logic [CRC_WIDTH-1:0] TAPS =
    {1'b1, {(CRC_WIDTH-1){1'b0}}} | POLY;

  logic fb;

  assign fb     = data_i ^ lfsr_i[0];
  assign lfsr_o = (lfsr_i >> 1) ^ (fb ? TAPS : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker with per-frame reseed.
// Generate frames shift the CRC out LSB first; check frames flag residue.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(CRC8_POLY),
  parameter logic [CRC_WIDTH-1:0] SEED = CRC_WIDTH'(CRC8_SEED)
) (
  input logic CLK,
  input logic RST,
  crc_serial_engine_if.slave bus
);

  localparam int unsigned CW = $clog2(CRC_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CRC_WIDTH);

  state_e state_q, state_d;
  logic [CRC_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CRC_WIDTH-1:0] step_in, step_out;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic crc_q, crc_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic err_q, err_d;

  // Frame starts (IDLE or OUT) always step from SEED.
  assign step_in = (state_q == ST_SHIFT) ? lfsr_q : SEED;

  crc_lfsr_step #(
    .CRC_WIDTH(CRC_WIDTH),
    .POLY     (POLY)
  ) u_step (
    .lfsr_i(step_in),
    .data_i(bus.DATA),
    .lfsr_o(step_out)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    crc_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.ACTIVE) begin
          lfsr_d  = step_out;
          mode_d  = bus.MODE;
          state_d = ST_SHIFT;
        end else begin
          lfsr_d = SEED;
        end
      end
      ST_SHIFT: begin
        if (bus.ACTIVE) begin
          lfsr_d = step_out;
        end else if (mode_q == MODE_GEN) begin
          crc_d   = lfsr_q[0];
          valid_d = 1'b1;
          lfsr_d  = lfsr_q >> 1;
          cnt_d   = CW'(1);
          state_d = ST_OUT;
        end else begin
          done_d  = 1'b1;
          err_d   = |lfsr_q;
          lfsr_d  = SEED;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (bus.ACTIVE) begin
          lfsr_d  = step_out;
          mode_d  = bus.MODE;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (cnt_q < CNT_LAST) begin
          crc_d   = lfsr_q[0];
          valid_d = 1'b1;
          lfsr_d  = lfsr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          lfsr_d  = SEED;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        lfsr_d  = SEED;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.CRC      = crc_q;
  assign bus.VALID    = valid_q;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.CHK_DONE = done_q;
  assign bus.CHK_ERR  = err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: CRC-8 defaults plus a
// 16-bit instance cross-checked against a bit-serial reference.
module tb_crc_serial_engine;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  crc_serial_engine_if if8 ();
  crc_serial_engine_if if16 ();

  crc_serial_engine dut8 (
    .CLK(CLK),
    .RST(RST),
    .bus(if8.slave)
  );

  crc_serial_engine #(
    .CRC_WIDTH(16),
    .POLY     (16'h8408),
    .SEED     (16'hFFFF)
  ) dut16 (
    .CLK(CLK),
    .RST(RST),
    .bus(if16.slave)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic d8(input logic a, input logic d, input logic m);
    if8.ACTIVE = a;
    if8.DATA   = d;
    if8.MODE   = m;
    @(posedge CLK);
    #1;
  endtask

  task automatic d16(input logic a, input logic d, input logic m);
    if16.ACTIVE = a;
    if16.DATA   = d;
    if16.MODE   = m;
    @(posedge CLK);
    #1;
  endtask

  // MODE is only honoured on the first bit; later bits drive its inverse.
  task automatic send8(input logic [31:0] bits, input int n,
                       input logic m);
    for (int i = 0; i < n; i++)
      d8(1'b1, bits[i], (i == 0) ? m : ~m);
  endtask

  task automatic send16(input logic [31:0] bits, input int n,
                        input logic m);
    for (int i = 0; i < n; i++)
      d16(1'b1, bits[i], (i == 0) ? m : ~m);
  endtask

  task automatic gen8(output logic [7:0] crc, output int vc,
                      output logic bz, output logic [1:0] tail);
    crc = '0;
    vc  = 0;
    bz  = 1'b1;
    d8(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      crc[i] = if8.CRC;
      vc += int'(if8.VALID);
      bz &= if8.BUSY;
      d8(1'b0, 1'b0, 1'b0);
    end
    tail = {if8.VALID, if8.BUSY};
  endtask

  function automatic logic [15:0] ref16(input logic [31:0] bits,
                                        input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (r[0] ^ bits[i]) r = (r >> 1) ^ 16'h8408;
      else                r = r >> 1;
    end
    return r;
  endfunction

  task automatic test_reset();
    logic [7:0] crc;
    int vc;
    logic bz;
    logic [1:0] tail;
    RST = 1'b0;
    d8(1'b1, 1'b1, 1'b1);
    d8(1'b1, 1'b1, 1'b1);
    nvec++;
    if ({if8.CRC, if8.VALID, if8.BUSY, if8.CHK_DONE, if8.CHK_ERR}
        !== 5'b0) begin
      nerr++;
      $display("FAIL reset_outs got %b want 00000",
        {if8.CRC, if8.VALID, if8.BUSY, if8.CHK_DONE, if8.CHK_ERR});
    end
    RST = 1'b1;
    d8(1'b0, 1'b0, 1'b0);
    send8(32'h0, 8, 1'b0);
    d8(1'b0, 1'b0, 1'b0);
    d8(1'b0, 1'b0, 1'b0);
    d8(1'b0, 1'b0, 1'b0);
    nvec++;
    if (if8.VALID !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset_valid got %b want 1", if8.VALID);
    end
    RST = 1'b0;
    d8(1'b0, 1'b0, 1'b0);
    nvec++;
    if ({if8.CRC, if8.VALID, if8.BUSY, if8.CHK_DONE, if8.CHK_ERR}
        !== 5'b0) begin
      nerr++;
      $display("FAIL midout_reset_outs got %b want 00000",
        {if8.CRC, if8.VALID, if8.BUSY, if8.CHK_DONE, if8.CHK_ERR});
    end
    nvec++;
    if (dut8.state_q !== crc_pkg::ST_IDLE) begin
      nerr++;
      $display("FAIL reset_state got %0d want 0", dut8.state_q);
    end
    nvec++;
    if (dut8.lfsr_q !== 8'hD8) begin
      nerr++;
      $display("FAIL reset_lfsr got %h want d8", dut8.lfsr_q);
    end
    RST = 1'b1;
    d8(1'b0, 1'b0, 1'b0);
    send8(32'h0, 8, 1'b0);
    gen8(crc, vc, bz, tail);
    nvec++;
    if (crc !== 8'h14) begin
      nerr++;
      $display("FAIL post_reset_crc got %h want 14", crc);
    end
  endtask

  task automatic test_gen_zeros();
    logic [7:0] crc;
    int vc;
    logic bz;
    logic [1:0] tail;
    send8(32'h0, 8, 1'b0);
    gen8(crc, vc, bz, tail);
    nvec++;
    if (crc !== 8'h14) begin
      nerr++;
      $display("FAIL gen_zeros_crc got %h want 14", crc);
    end
    nvec++;
    if (vc !== 8) begin
      nerr++;
      $display("FAIL gen_zeros_valid_cnt got %0d want 8", vc);
    end
    nvec++;
    if (bz !== 1'b1) begin
      nerr++;
      $display("FAIL gen_zeros_busy got %b want 1", bz);
    end
    nvec++;
    if (tail !== 2'b00) begin
      nerr++;
      $display("FAIL gen_zeros_tail got %b want 00", tail);
    end
  endtask

  task automatic test_check();
    int flips[4] = '{0, 5, 10, 15};
    send8(32'h1400, 16, 1'b1);
    d8(1'b0, 1'b0, 1'b0);
    nvec++;
    if ({if8.CHK_DONE, if8.CHK_ERR, if8.VALID} !== 3'b100) begin
      nerr++;
      $display("FAIL chk_good got %b want 100",
        {if8.CHK_DONE, if8.CHK_ERR, if8.VALID});
    end
    d8(1'b0, 1'b0, 1'b0);
    nvec++;
    if (if8.CHK_DONE !== 1'b0) begin
      nerr++;
      $display("FAIL chk_done_pulse got %b want 0", if8.CHK_DONE);
    end
    foreach (flips[k]) begin
      send8(32'h1400 ^ (32'h1 << flips[k]), 16, 1'b1);
      d8(1'b0, 1'b0, 1'b0);
      nvec++;
      if ({if8.CHK_DONE, if8.CHK_ERR} !== 2'b11) begin
        nerr++;
        $display("FAIL chk_flip%0d got %b want 11",
          flips[k], {if8.CHK_DONE, if8.CHK_ERR});
      end
      d8(1'b0, 1'b0, 1'b0);
      nvec++;
      if ({if8.CHK_DONE, if8.CHK_ERR} !== 2'b01) begin
        nerr++;
        $display("FAIL chk_hold%0d got %b want 01",
          flips[k], {if8.CHK_DONE, if8.CHK_ERR});
      end
    end
    send8(32'h1400, 16, 1'b1);
    d8(1'b0, 1'b0, 1'b0);
    nvec++;
    if ({if8.CHK_DONE, if8.CHK_ERR} !== 2'b10) begin
      nerr++;
      $display("FAIL chk_recover got %b want 10",
        {if8.CHK_DONE, if8.CHK_ERR});
    end
    d8(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_one_bit();
    logic [7:0] crc;
    int vc;
    logic bz;
    logic [1:0] tail;
    send8(32'h1, 1, 1'b0);
    gen8(crc, vc, bz, tail);
    nvec++;
    if ({crc, vc[3:0]} !== {8'hA8, 4'd8}) begin
      nerr++;
      $display("FAIL one_bit got crc %h vcnt %0d want a8 8", crc, vc);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] head;
    logic [7:0] crc;
    int vc;
    logic bz;
    logic [1:0] tail;
    send8(32'h0, 8, 1'b0);
    d8(1'b0, 1'b0, 1'b0);
    head[0] = if8.CRC;
    d8(1'b0, 1'b0, 1'b0);
    head[1] = if8.CRC;
    d8(1'b0, 1'b0, 1'b0);
    head[2] = if8.CRC;
    nvec++;
    if (head !== 3'b100) begin
      nerr++;
      $display("FAIL abandon_head got %b want 100", head);
    end
    d8(1'b1, 1'b1, 1'b0);
    nvec++;
    if ({if8.VALID, if8.BUSY} !== 2'b01) begin
      nerr++;
      $display("FAIL abandon_valid got %b want 01",
        {if8.VALID, if8.BUSY});
    end
    gen8(crc, vc, bz, tail);
    nvec++;
    if (crc !== 8'hA8) begin
      nerr++;
      $display("FAIL abandon_newcrc got %h want a8", crc);
    end
    send8(32'h0, 8, 1'b0);
    gen8(crc, vc, bz, tail);
    nvec++;
    if (crc !== 8'h14) begin
      nerr++;
      $display("FAIL abandon_next got %h want 14", crc);
    end
  endtask

  task automatic test_wide_random();
    logic [31:0] bits;
    logic [15:0] exp;
    logic [15:0] got;
    int n;
    int vc;
    logic m;
    for (int f = 0; f < 1000; f++) begin
      n    = int'($urandom_range(1, 16));
      bits = $urandom & ((32'h1 << n) - 32'h1);
      m    = 1'($urandom % 2);
      exp  = ref16(bits, n);
      if (m == 1'b0) begin
        send16(bits, n, 1'b0);
        d16(1'b0, 1'b0, 1'b0);
        got = '0;
        vc  = 0;
        for (int i = 0; i < 16; i++) begin
          got[i] = if16.CRC;
          vc += int'(if16.VALID);
          d16(1'b0, 1'b0, 1'b0);
        end
        nvec++;
        if ({got, vc[4:0], if16.VALID} !== {exp, 5'd16, 1'b0}) begin
          nerr++;
          $display("FAIL wide_gen f%0d got %h/%0d want %h/16",
            f, got, vc, exp);
        end
      end else begin
        send16(bits | ({16'h0, exp} << n), n + 16, 1'b1);
        d16(1'b0, 1'b0, 1'b0);
        nvec++;
        if ({if16.CHK_DONE, if16.CHK_ERR} !== 2'b10) begin
          nerr++;
          $display("FAIL wide_chk f%0d got %b want 10",
            f, {if16.CHK_DONE, if16.CHK_ERR});
        end
      end
    end
  endtask

  initial begin
    if8.ACTIVE  = 1'b0;
    if8.DATA    = 1'b0;
    if8.MODE    = 1'b0;
    if16.ACTIVE = 1'b0;
    if16.DATA   = 1'b0;
    if16.MODE   = 1'b0;
    test_reset();
    test_gen_zeros();
    test_check();
    test_one_bit();
    test_back_to_back();
    test_wide_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
